// File: rtl/sync_ram.sv
// sync_ram: simple-dual-port synchronous RAM (one write port, one read port,
// single clock) with a registered read output, a read-valid strobe, and a
// clear sequencer that fills every word with INIT_VAL after reset.
//
// Optional feature macro: SYNC_RAM_BYPASS_EN
//   defined     -> write-first: a same-address read and write returns the new WD
//   not defined -> read-first:  a same-address read and write returns the old word
// COLL is raised one cycle after a same-address read and write in both builds.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_INIT  | clear sequencer writes INIT_VAL to every word; requests ignored
// S_READY | clear done, RDY high, read and write ports accept requests

module sync_ram #(
  parameter int                AWIDTH   = 8,
  parameter int                DWIDTH   = 8,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              CK,
  input  logic              CLR,
  input  logic              WE,
  input  logic [AWIDTH-1:0] WA,
  input  logic [DWIDTH-1:0] WD,
  input  logic              RE,
  input  logic [AWIDTH-1:0] RA,
  output logic [DWIDTH-1:0] RD,
  output logic              RV,
  output logic              RDY,
  output logic              COLL
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic [DWIDTH-1:0]   rd_q, rd_d;
  logic                rv_q, rv_d;
  logic                coll_q, coll_d;

  // Storage is deliberately not reset: the clear sequence rewrites every word.
  logic [DWIDTH-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [AWIDTH-1:0]   mem_wa;
  logic [DWIDTH-1:0]   mem_wd;
  logic                same_addr;
  logic [DWIDTH-1:0]   rd_src;

  // Next state, clear counter and the shared write-port mux (sequencer vs. user).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = INIT_VAL;
    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // The last word is written on this edge; the counter wraps to 0 naturally.
        if (cnt_q == {AWIDTH{1'b1}}) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        mem_we = WE;
        mem_wa = WA;
        mem_wd = WD;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Read path: select old or bypassed data, raise RV and COLL for accepted reads.
  always_comb begin
    same_addr = WE && (WA == RA);
`ifdef SYNC_RAM_BYPASS_EN
    rd_src    = same_addr ? WD : mem_q[RA];
`else
    rd_src    = mem_q[RA];
`endif
    rd_d      = rd_q;
    rv_d      = 1'b0;
    coll_d    = 1'b0;
    if (state_q == S_READY && RE) begin
      rd_d   = rd_src;
      rv_d   = 1'b1;
      coll_d = same_addr;
    end
  end

  // Control and output registers; CLR low clears them without waiting for CK.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rd_q    <= '0;
      rv_q    <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      coll_q  <= coll_d;
    end
  end

  // Single write port into the storage array.
  always_ff @(posedge CK) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign RD   = rd_q;
  assign RV   = rv_q;
  assign COLL = coll_q;
  assign RDY  = (state_q == S_READY);

endmodule

// File: tb/tb_sync_ram.sv
// Testbench for sync_ram (AWIDTH=4, DWIDTH=8, INIT_VAL=8'hA5).
// Stimulus pushes the expected read response into a queue; a monitor on the
// falling edge pops and compares whenever RV is high.

module tb_sync_ram;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [DW-1:0] IV = 8'hA5;

`ifdef SYNC_RAM_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = 8'h22;
`else
  localparam logic [DW-1:0] COLL_EXP = 8'h11;
`endif

  logic          CK = 1'b0;
  logic          CLR = 1'b1;
  logic          WE = 1'b0;
  logic [AW-1:0] WA = '0;
  logic [DW-1:0] WD = '0;
  logic          RE = 1'b0;
  logic [AW-1:0] RA = '0;
  logic [DW-1:0] RD;
  logic          RV;
  logic          RDY;
  logic          COLL;

  sync_ram #(
    .AWIDTH  (AW),
    .DWIDTH  (DW),
    .INIT_VAL(IV)
  ) dut (
    .CK  (CK),
    .CLR (CLR),
    .WE  (WE),
    .WA  (WA),
    .WD  (WD),
    .RE  (RE),
    .RA  (RA),
    .RD  (RD),
    .RV  (RV),
    .RDY (RDY),
    .COLL(COLL)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [DW-1:0] rd;
    logic          coll;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented read against the head of the scoreboard.
  always @(negedge CK) begin
    if (RV === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rv: got RV=1 RD=%0h expected no read", RD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        n_vec++;
        if (RD !== e.rd || COLL !== e.coll) begin
          n_err++;
          $display("FAIL read_data: got RD=%0h COLL=%0b expected RD=%0h COLL=%0b",
                   RD, COLL, e.rd, e.coll);
        end
      end
    end else if (COLL !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL coll_no_rv: got COLL=%0b expected 0", COLL);
    end
  end

  // Drive one cycle of requests (called just after a rising edge).
  task automatic issue(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [DW-1:0] exp_rd, input logic exp_coll);
    exp_t e;
    WE = we; WA = wa; WD = wd; RE = re; RA = ra;
    if (re) begin
      e.rd = exp_rd;
      e.coll = exp_coll;
      sb.push_back(e);
    end
    @(posedge CK); #1;
  endtask

  task automatic idle();
    issue(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Count rising edges until RDY is seen; 0 means it never came.
  task automatic wait_rdy(output int edges);
    edges = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge CK); #1;
      if (RDY === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int base;

    // Reset with write and read requests held through the clear sequence.
    WE = 1'b1; WA = 4'd3; WD = 8'h5A; RE = 1'b1; RA = 4'd3;
    #1 CLR = 1'b0;
    #2;
    chk("rst_rdy",  32'(RDY),  32'd0);
    chk("rst_rv",   32'(RV),   32'd0);
    chk("rst_coll", 32'(COLL), 32'd0);
    chk("rst_rd",   32'(RD),   32'h0);
    @(negedge CK); #1;
    CLR = 1'b1;
    wait_rdy(edges);
    chk("clear_edges", 32'(edges), 32'd16);

    // Back-to-back reads of all words: INIT_VAL everywhere, address 3 untouched.
    base = n_pop;
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, '0, '0, 1'b1, AW'(a), IV, 1'b0);
    end
    idle();
    chk("clear_reads", 32'(n_pop - base), 32'd16);

    // Basic write then read, then RE=0 holds RD.
    issue(1'b1, 4'd5, 8'h3C, 1'b0, '0, '0, 1'b0);
    issue(1'b0, '0, '0, 1'b1, 4'd5, 8'h3C, 1'b0);
    idle();
    chk("hold_rv", 32'(RV), 32'd0);
    chk("hold_rd", 32'(RD), 32'h3C);

    // Collision on address 7, then a follow-up read sees the new value.
    issue(1'b1, 4'd7, 8'h11, 1'b0, '0, '0, 1'b0);
    issue(1'b1, 4'd7, 8'h22, 1'b1, 4'd7, COLL_EXP, 1'b1);
    issue(1'b0, '0, '0, 1'b1, 4'd7, 8'h22, 1'b0);
    // Write and read at different addresses do not interact.
    issue(1'b1, 4'd9, 8'h44, 1'b1, 4'd7, 8'h22, 1'b0);
    issue(1'b0, '0, '0, 1'b1, 4'd9, 8'h44, 1'b0);
    idle();

    // Reset mid-READY while RV, COLL and RD are all active.
    issue(1'b1, 4'd2, 8'hFF, 1'b0, '0, '0, 1'b0);
    issue(1'b1, 4'd2, 8'hFF, 1'b1, 4'd2, 8'hFF, 1'b1);
    WE = 1'b0; RE = 1'b0;
    @(negedge CK); #1;
    CLR = 1'b0;
    #1;
    chk("mid_rdy",  32'(RDY),  32'd0);
    chk("mid_rv",   32'(RV),   32'd0);
    chk("mid_coll", 32'(COLL), 32'd0);
    chk("mid_rd",   32'(RD),   32'h0);
    @(negedge CK); #1;
    CLR = 1'b1;
    wait_rdy(edges);
    chk("reclear_edges", 32'(edges), 32'd16);
    issue(1'b0, '0, '0, 1'b1, 4'd2, IV, 1'b0);
    issue(1'b0, '0, '0, 1'b1, 4'd5, IV, 1'b0);
    idle();
    idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
